// File: rtl/uart_rx_char.sv
// 8N1 serial character receiver with 2-FF input synchronizer and mid-bit sampling.
// Define UART_RX_PARITY_EN to receive 8E1 frames with a live o_perr strobe.
module uart_rx_char #(
  parameter int D = 234
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_ferr,
  output logic       o_perr,
  output logic       o_led,
  output logic [2:0] o_state
);

  localparam int CW = $clog2(D);
  localparam logic [CW-1:0] HALF_LOAD = CW'(D / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(D - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t         state;
  logic           sync1;
  logic           rxd_s;
  logic [CW-1:0]  clk_cnt;
  logic [3:0]     bit_cnt;
  logic [7:0]     shreg;
`ifdef UART_RX_PARITY_EN
  logic           par_bad;
`endif

  assign o_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= i_rxd;
      rxd_s <= sync1;
    end
  end

  // clk_cnt counts down to the next sample point and reloads there.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      o_data  <= 8'h00;
      o_valid <= 1'b0;
      o_ferr  <= 1'b0;
      o_led   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_perr  <= 1'b0;
      par_bad <= 1'b0;
`endif
    end else begin
      o_valid <= 1'b0;
      o_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_perr  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            state   <= S_START;
            clk_cnt <= HALF_LOAD;
            bit_cnt <= '0;
          end
        end
        S_START: begin
          if (clk_cnt == '0) begin
            if (rxd_s) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              clk_cnt <= FULL_LOAD;
            end
          end else begin
            clk_cnt <= clk_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (clk_cnt == '0) begin
            shreg   <= {rxd_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            clk_cnt <= FULL_LOAD;
            if (bit_cnt == 4'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            clk_cnt <= clk_cnt - 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (clk_cnt == '0) begin
            par_bad <= (rxd_s != ^shreg);
            clk_cnt <= FULL_LOAD;
            state   <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (clk_cnt == '0) begin
            if (rxd_s) begin
              state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                o_perr <= 1'b1;
              end else begin
                o_data  <= shreg;
                o_valid <= 1'b1;
                o_led   <= ~o_led;
              end
`else
              o_data  <= shreg;
              o_valid <= 1'b1;
              o_led   <= ~o_led;
`endif
            end else begin
              // Framing error outranks parity; wait out the low line in BREAK.
              o_ferr <= 1'b1;
              state  <= S_BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt - 1'b1;
          end
        end
        S_BREAK: begin
          if (rxd_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign o_perr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_char.sv
// Randomized scoreboard bench for uart_rx_char: frames are modelled as bit lists,
// expected strobes are queued at send time and matched by an independent monitor.
module tb_uart_rx_char;

  localparam int D = 5;
  localparam logic [1:0] K_VALID = 2'd1;
  localparam logic [1:0] K_FERR  = 2'd2;
  localparam logic [1:0] K_PERR  = 2'd3;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_ferr;
  logic       o_perr;
  logic       o_led;
  logic [2:0] o_state;

  uart_rx_char #(.D(D)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_rxd   (rxd),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ferr  (o_ferr),
    .o_perr  (o_perr),
    .o_led   (o_led),
    .o_state (o_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // entry = {kind[1:0], expected o_led, expected o_data}
  logic [10:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  good_data = 8'h00;
  logic        led_m = 1'b0;
  int          last_valid_cyc = 0;
  int          frame_start_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && (o_valid || o_ferr || o_perr)) begin
      logic [1:0]  obs_kind;
      logic [10:0] e;
      obs_kind = 2'd0;
      if (o_valid && !o_ferr && !o_perr) obs_kind = K_VALID;
      if (!o_valid && o_ferr && !o_perr) obs_kind = K_FERR;
      if (!o_valid && !o_ferr && o_perr) obs_kind = K_PERR;
      if (o_valid) last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {o_valid, o_ferr, o_perr}, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", obs_kind, e[10:9]);
        check("o_data", o_data, e[7:0]);
        check("o_led", o_led, e[8]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driving starts 1 time unit after a rising edge.
  task automatic drive_bit(input logic b, input int ncyc);
    rxd = b;
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_wrong);
    logic par;
    if (!stop_bit) begin
      exp_q.push_back({K_FERR, led_m, good_data});
`ifdef UART_RX_PARITY_EN
    end else if (par_wrong) begin
      exp_q.push_back({K_PERR, led_m, good_data});
`endif
    end else begin
      good_data = b;
      led_m = ~led_m;
      exp_q.push_back({K_VALID, led_m, good_data});
    end
    par = (^b) ^ par_wrong;
    frame_start_cyc = cyc;
    drive_bit(1'b0, D);
    for (int k = 0; k < 8; k++) drive_bit(b[k], D);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, D);
`else
    if (par) begin end
`endif
    drive_bit(stop_bit, D);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rxd = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", o_data, 8'h00);
    check("reset_pulses", {o_valid, o_ferr, o_perr, o_led}, 0);
    rst_n = 1'b1;
    drive_bit(1'b1, 2 * D);

    // 1: ideal frame, latency = T0+48 plus two synchronizer stages
    send_frame(8'h41, 1'b1, 1'b0);
    drive_bit(1'b1, 2 * D);
    wait_drain("t1");
    check("t1_led", o_led, 1);
    checks++;
    if ((last_valid_cyc - frame_start_cyc) < 50 || (last_valid_cyc - frame_start_cyc) > 51) begin
      failures++;
      $display("FAIL t1_latency: got %0d cycles expected 50..51", last_valid_cyc - frame_start_cyc);
    end

    // 2: two-cycle glitch must not produce anything
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 4 * D);
    wait_drain("t2");
    check("t2_data_held", o_data, good_data);

    // 3: framing error followed by a 300 ns low hold
    send_frame(8'h55, 1'b0, 1'b0);
    drive_bit(1'b0, 15);
    drive_bit(1'b1, 3 * D);
    wait_drain("t3");
    check("t3_data_held", o_data, 8'h41);

    // 4: ten back-to-back frames
    for (int i = 0; i < 10; i++) send_frame(8'h30 + 8'(i), 1'b1, 1'b0);
    drive_bit(1'b1, 2 * D);
    wait_drain("t4");
    check("t4_last_data", o_data, 8'h39);
    check("t4_led", o_led, led_m);

    // 5: reset during data bit 4
    drive_bit(1'b0, D);
    for (int k = 0; k < 4; k++) drive_bit(k == 0 ? 1'b0 : 1'b1, D);
    drive_bit(1'b1, 2);
    rst_n = 1'b0;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_reset_data", o_data, 8'h00);
    check("t5_reset_led", o_led, 0);
    good_data = 8'h00;
    led_m = 1'b0;
    rst_n = 1'b1;
    drive_bit(1'b1, 2 * D);
    send_frame(8'h7E, 1'b1, 1'b0);
    drive_bit(1'b1, 2 * D);
    wait_drain("t5");
    check("t5_data", o_data, 8'h7E);

`ifdef UART_RX_PARITY_EN
    // 6: wrong then correct parity
    send_frame(8'h03, 1'b1, 1'b1);
    drive_bit(1'b1, D);
    send_frame(8'h03, 1'b1, 1'b0);
    drive_bit(1'b1, 2 * D);
    wait_drain("t6");
    check("t6_data", o_data, 8'h03);
`endif

    // random frames with random gaps and phases
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      logic       stop_ok;
      logic       pw;
      b = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 5) != 0);
      pw = 1'b0;
`ifdef UART_RX_PARITY_EN
      pw = ($urandom_range(0, 4) == 0);
`endif
      send_frame(b, stop_ok, pw);
      if (!stop_ok) drive_bit(1'b0, $urandom_range(0, 3 * D));
      drive_bit(1'b1, (stop_ok ? 0 : D) + $urandom_range(0, 2 * D));
    end
    drive_bit(1'b1, 3 * D);
    wait_drain("rand");
    check("rand_data", o_data, good_data);
    check("rand_led", o_led, led_m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
